// File: rtl/stream_buffer.sv
// -----------------------------------------------------------------------------
// stream_buffer
//
// Single-clock AXI-Stream FIFO buffer between an upstream slave port (s01_*)
// and a downstream master port (m01_*). Each stored entry carries the data
// word together with its byte strobe and end-of-packet flag. Also reports
// the current fill level, a running count of packets delivered downstream,
// and (optionally) the largest data word accepted since reset.
//
// Parameters
//   DATA_WIDTH : tdata width in bits (multiple of 8)
//   DEPTH      : word capacity (power of 2, >= 2)
//
// Ports
//   axis_aclk        in   sole clock, rising edge
//   axis_areset      in   synchronous active-high reset
//   s01_axis_tdata   in   upstream data word
//   s01_axis_tstrb   in   upstream byte strobe (stored with the word)
//   s01_axis_tvalid  in   upstream word valid
//   s01_axis_tlast   in   upstream end-of-packet (stored with the word)
//   s01_axis_tready  out  buffer can accept a word
//   m01_axis_tdata   out  head word
//   m01_axis_tstrb   out  head strobe
//   m01_axis_tvalid  out  head word valid
//   m01_axis_tlast   out  head end-of-packet
//   m01_axis_tready  in   downstream accepts head word
//   fill_level       out  words currently stored (0..DEPTH)
//   packet_count     out  packets fully delivered downstream (wraps at 16 bits)
//   peak_value       out  largest unsigned tdata accepted since reset
//
// Build option
//   STREAM_BUFFER_PEAK_TRACK_EN : when defined, peak_value tracks the largest
//   accepted word; when undefined, peak_value is tied to zero.
// -----------------------------------------------------------------------------
module stream_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                        axis_aclk,
    input  logic                        axis_areset,

    input  logic [DATA_WIDTH-1:0]       s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]     s01_axis_tstrb,
    input  logic                        s01_axis_tvalid,
    input  logic                        s01_axis_tlast,
    output logic                        s01_axis_tready,

    output logic [DATA_WIDTH-1:0]       m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]     m01_axis_tstrb,
    output logic                        m01_axis_tvalid,
    output logic                        m01_axis_tlast,
    input  logic                        m01_axis_tready,

    output logic [$clog2(DEPTH):0]      fill_level,
    output logic [15:0]                 packet_count,
    output logic [DATA_WIDTH-1:0]       peak_value
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned EW = DATA_WIDTH + SW + 1;

    // DEPTH is a power of two, so "full" is just the top bit of the count.
    localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    // -------------------------------------------------------------------------
    // Handshake. Both sides are derived from the registered fill level only,
    // so a read in the same cycle never lets a full buffer accept, and there
    // is no combinational path from s01 to m01.
    // -------------------------------------------------------------------------
    assign full  = (fill_level == FULL_LEVEL);
    assign empty = (fill_level == '0);

    assign s01_axis_tready = !full  && !axis_areset;
    assign m01_axis_tvalid = !empty && !axis_areset;

    assign wr_en = s01_axis_tvalid && s01_axis_tready;
    assign rd_en = m01_axis_tvalid && m01_axis_tready;

    // -------------------------------------------------------------------------
    // Storage. Contents are not cleared on reset; the pointers and fill level
    // alone decide what is valid.
    // -------------------------------------------------------------------------
    assign wr_entry = {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};

    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // The head entry is only overwritten when the buffer is empty (wr_ptr ==
    // rd_ptr), so the m01 outputs stay stable while a word is stalled.
    assign rd_entry       = mem[rd_ptr];
    assign m01_axis_tdata = rd_entry[DATA_WIDTH-1:0];
    assign m01_axis_tstrb = rd_entry[DATA_WIDTH +: SW];
    assign m01_axis_tlast = rd_entry[EW-1];

    // -------------------------------------------------------------------------
    // Pointers, fill level and delivered-packet counter.
    // Pointer width is log2(DEPTH), so increments wrap modulo DEPTH.
    // -------------------------------------------------------------------------
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            packet_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (m01_axis_tlast) begin
                    packet_count <= packet_count + 1'b1;
                end
            end
            unique case ({wr_en, rd_en})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Peak tracking.
    // -------------------------------------------------------------------------
`ifdef STREAM_BUFFER_PEAK_TRACK_EN
    logic peak_seen;

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            peak_value <= '0;
            peak_seen  <= 1'b0;
        end else if (wr_en) begin
            peak_seen <= 1'b1;
            if (!peak_seen || (s01_axis_tdata > peak_value)) begin
                peak_value <= s01_axis_tdata;
            end
        end
    end
`else
    assign peak_value = '0;
`endif

endmodule

// File: tb/tb_stream_buffer.sv
module tb_stream_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;

`ifdef STREAM_BUFFER_PEAK_TRACK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [3:0]    s_tstrb;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [3:0]    m_tstrb;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [4:0]    fill_level;
    logic [15:0]   packet_count;
    logic [DW-1:0] peak_value;

    int tests = 0;
    int fails = 0;

    // Reference model: a plain queue of {last, strb, data} entries.
    logic [36:0]   mq[$];
    logic [15:0]   m_pkt;
    logic [DW-1:0] m_peak;

    stream_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .s01_axis_tdata  (s_tdata),
        .s01_axis_tstrb  (s_tstrb),
        .s01_axis_tvalid (s_tvalid),
        .s01_axis_tlast  (s_tlast),
        .s01_axis_tready (s_tready),
        .m01_axis_tdata  (m_tdata),
        .m01_axis_tstrb  (m_tstrb),
        .m01_axis_tvalid (m_tvalid),
        .m01_axis_tlast  (m_tlast),
        .m01_axis_tready (m_tready),
        .fill_level      (fill_level),
        .packet_count    (packet_count),
        .peak_value      (peak_value)
    );

    always #5 clk = ~clk;

    // Advance one clock; update the model from the inputs presented at the edge.
    task automatic tick();
        bit          wr;
        bit          rd;
        logic [36:0] e;
        wr = s_tvalid && !rst && (mq.size() < DEPTH);
        rd = m_tready && !rst && (mq.size() > 0);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_pkt  = '0;
            m_peak = '0;
        end else begin
            if (rd) begin
                e = mq.pop_front();
                if (e[36]) m_pkt = m_pkt + 16'd1;
            end
            if (wr) begin
                mq.push_back({s_tlast, s_tstrb, s_tdata});
                if (PEAK_EN && (s_tdata > m_peak)) m_peak = s_tdata;
            end
        end
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;
        s_tdata = '0; s_tstrb = '0; s_tlast = 1'b0;
        tick(); tick();
        #1;
        tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_tready got %b want 0", s_tready); end
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
        tests++; if (fill_level !== 5'd0) begin fails++; $display("FAIL reset_fill got %0d want 0", fill_level); end
        tests++; if (packet_count !== 16'd0) begin fails++; $display("FAIL reset_pkt got %0d want 0", packet_count); end
        tests++; if (peak_value !== '0) begin fails++; $display("FAIL reset_peak got %0h want 0", peak_value); end
        tick();
        rst = 1'b0;
        #1;
        tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL release_tready got %b want 1", s_tready); end
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL release_tvalid got %b want 0", m_tvalid); end
    endtask

    task automatic test_single();
        s_tdata = 32'h0000_00A5; s_tstrb = 4'hF; s_tlast = 1'b1; s_tvalid = 1'b1;
        m_tready = 1'b1;
        #1;
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL single_no_bypass got %b want 0", m_tvalid); end
        tick();
        s_tvalid = 1'b0;
        #1;
        tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL single_tvalid got %b want 1", m_tvalid); end
        tests++; if (m_tdata !== 32'h0000_00A5) begin fails++; $display("FAIL single_data got %h want 000000a5", m_tdata); end
        tests++; if (m_tlast !== 1'b1 || m_tstrb !== 4'hF) begin fails++; $display("FAIL single_last_strb got %b/%h want 1/f", m_tlast, m_tstrb); end
        tick();
        #1;
        tests++; if (packet_count !== 16'd1) begin fails++; $display("FAIL single_pkt got %0d want 1", packet_count); end
        tests++; if (fill_level !== 5'd0) begin fails++; $display("FAIL single_fill got %0d want 0", fill_level); end
    endtask

    task automatic test_fill_full();
        m_tready = 1'b0;
        s_tstrb  = 4'hF;
        for (int i = 1; i <= 16; i++) begin
            s_tdata = i; s_tlast = (i % 4 == 0); s_tvalid = 1'b1;
            #1;
            tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL fill_tready_%0d got %b want 1", i, s_tready); end
            tick();
        end
        s_tdata = 17; s_tlast = 1'b1;
        #1;
        tests++; if (fill_level !== 5'd16) begin fails++; $display("FAIL full_fill got %0d want 16", fill_level); end
        tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL full_tready got %b want 0", s_tready); end
        tick();
        #1;
        tests++; if (fill_level !== 5'd16 || m_tdata !== 32'd1) begin fails++; $display("FAIL full_hold got fill %0d head %0d want 16/1", fill_level, m_tdata); end
        // Full with write and read offered together: read only.
        m_tready = 1'b1;
        tick();
        #1;
        tests++; if (fill_level !== 5'd15) begin fails++; $display("FAIL full_rw_fill got %0d want 15", fill_level); end
        tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL full_rw_tready got %b want 1", s_tready); end
        tick();
        s_tvalid = 1'b0;
        for (int c = 0; c < 40 && mq.size() > 0; c++) begin
            #1;
            tests++; if (m_tvalid !== 1'b1 || {m_tlast, m_tstrb, m_tdata} !== mq[0]) begin
                fails++; $display("FAIL drain_head got %b %h want %h", m_tvalid, {m_tlast, m_tstrb, m_tdata}, mq[0]);
            end
            tick();
        end
        #1;
        tests++; if (fill_level !== 5'd0 || packet_count !== m_pkt) begin fails++; $display("FAIL drain_end got fill %0d pkt %0d want 0/%0d", fill_level, packet_count, m_pkt); end
    endtask

    task automatic test_back_to_back();
        s_tvalid = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_tdata = $urandom; s_tstrb = 4'($urandom); s_tlast = 1'($urandom);
            #1;
            if (i > 0) begin
                tests++; if (fill_level !== 5'd1) begin fails++; $display("FAIL b2b_fill_%0d got %0d want 1", i, fill_level); end
                tests++; if ({m_tlast, m_tstrb, m_tdata} !== mq[0]) begin fails++; $display("FAIL b2b_data_%0d got %h want %h", i, {m_tlast, m_tstrb, m_tdata}, mq[0]); end
            end
            tick();
        end
        s_tvalid = 1'b0;
        tick();
        #1;
        tests++; if (fill_level !== 5'd0 || packet_count !== m_pkt) begin fails++; $display("FAIL b2b_end got fill %0d pkt %0d want 0/%0d", fill_level, packet_count, m_pkt); end
    endtask

    task automatic test_peak();
        logic [DW-1:0] vals [3];
        logic [DW-1:0] want [3];
        vals = '{32'd5, 32'd200, 32'd17};
        want = '{32'd5, 32'd200, 32'd200};
        rst = 1'b1; tick(); rst = 1'b0;
        m_tready = 1'b1; s_tstrb = 4'hF; s_tlast = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_tdata = vals[k]; s_tvalid = 1'b1;
            tick();
            s_tvalid = 1'b0;
            #1;
            tests++; if (peak_value !== (PEAK_EN ? want[k] : 32'd0)) begin
                fails++; $display("FAIL peak_%0d got %0d want %0d", k, peak_value, PEAK_EN ? want[k] : 32'd0);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m_tready = 1'b0; s_tvalid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_tdata = $urandom; s_tstrb = 4'($urandom); s_tlast = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        #1;
        tests++; if (fill_level !== 5'd7) begin fails++; $display("FAIL mid_fill_pre got %0d want 7", fill_level); end
        rst = 1'b1;
        tick();
        #1;
        tests++; if (fill_level !== 5'd0 || m_tvalid !== 1'b0 || packet_count !== 16'd0) begin
            fails++; $display("FAIL mid_reset got fill %0d tvalid %b pkt %0d want 0/0/0", fill_level, m_tvalid, packet_count);
        end
        rst = 1'b0;
        tick();
        #1;
        tests++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin fails++; $display("FAIL mid_release got tvalid %b tready %b want 0/1", m_tvalid, s_tready); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            s_tvalid = ($urandom_range(0, 3) != 0);
            m_tready = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            if (i % 150 < 40) m_tready = ($urandom_range(0, 5) == 0);
            s_tdata  = $urandom; s_tstrb = 4'($urandom); s_tlast = ($urandom_range(0, 3) == 0);
            #1;
            tests++; if (s_tready !== (!rst && mq.size() < DEPTH)) begin fails++; $display("FAIL rnd_tready_%0d got %b", i, s_tready); end
            tests++; if (m_tvalid !== (!rst && mq.size() > 0)) begin fails++; $display("FAIL rnd_tvalid_%0d got %b", i, m_tvalid); end
            tests++; if (fill_level !== 5'(mq.size())) begin fails++; $display("FAIL rnd_fill_%0d got %0d want %0d", i, fill_level, mq.size()); end
            tests++; if (packet_count !== m_pkt) begin fails++; $display("FAIL rnd_pkt_%0d got %0d want %0d", i, packet_count, m_pkt); end
            tests++; if (peak_value !== m_peak) begin fails++; $display("FAIL rnd_peak_%0d got %h want %h", i, peak_value, m_peak); end
            if (!rst && mq.size() > 0) begin
                tests++; if ({m_tlast, m_tstrb, m_tdata} !== mq[0]) begin fails++; $display("FAIL rnd_head_%0d got %h want %h", i, {m_tlast, m_tstrb, m_tdata}, mq[0]); end
            end
            tick();
        end
        rst = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    endtask

    initial begin
        m_pkt = '0; m_peak = '0;
        test_reset();
        test_single();
        test_fill_full();
        test_back_to_back();
        test_peak();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
